// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - handshake bundle for the pipelined immediate generator
//
// Purpose: groups the upstream instruction stream, the downstream immediate
// stream and the error counter into one bundle.
//   upstream   : inValid/inReady, instr, extOp, inTag
//   downstream : outValid/outReady, imm, outTag, illegal
//   status     : errCount
// Modports: slave = the generator itself, master = the surrounding pipeline.

interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             inValid;
   logic             inReady;
   logic [31:0]      instr;
   logic [2:0]       extOp;
   logic [TAG_W-1:0] inTag;
   logic             outValid;
   logic             outReady;
   logic [XLEN-1:0]  imm;
   logic [TAG_W-1:0] outTag;
   logic             illegal;
   logic [7:0]       errCount;

   modport slave (
      input  inValid, instr, extOp, inTag, outReady,
      output inReady, outValid, imm, outTag, illegal, errCount
   );

   modport master (
      output inValid, instr, extOp, inTag, outReady,
      input  inReady, outValid, imm, outTag, illegal, errCount
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with 2-entry skid buffer
//
// Purpose: decodes the immediate of an instruction word for the selected
// format (I/U/S/B/J/Z), registers it with its tag and an illegal-format flag,
// and presents it downstream one cycle after acceptance. A main output register
// plus one skid register absorb back-pressure; inReady is registered.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - imm_gen_pipe_if.slave (in/out handshakes, imm, tag, illegal, errCount)

module imm_gen_pipe #(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 5,
   parameter int ZIMM_EN = 1
) (
   input  logic               clk,
   input  logic               rst,
   imm_gen_pipe_if.slave      bus
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

   occ_t             state, state_next;
   logic             in_ready_q;
   logic [XLEN-1:0]  main_imm, skid_imm;
   logic [TAG_W-1:0] main_tag, skid_tag;
   logic             main_ill, skid_ill;
   logic [7:0]       err_cnt;

   logic             accept, xfer;
   logic             load_main_new, load_main_skid, load_skid;
   logic [31:0]      imm32;
   logic [XLEN-1:0]  imm_calc;
   logic             ill_calc;

   // Immediate decode. Every format is first built as a 32-bit value; Z has
   // bit 31 clear, so a single sign extension to XLEN serves all formats.
   always_comb begin
      imm32    = '0;
      ill_calc = 1'b0;
      case (bus.extOp)
         3'd0: imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
         3'd1: imm32 = {bus.instr[31:12], 12'b0};
         3'd2: imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
         3'd3: imm32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                        bus.instr[30:25], bus.instr[11:8], 1'b0};
         3'd4: imm32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                        bus.instr[20], bus.instr[30:21], 1'b0};
         3'd5: begin
            if (ZIMM_EN != 0) imm32 = {27'b0, bus.instr[19:15]};
            else              ill_calc = 1'b1;
         end
         default: ill_calc = 1'b1;
      endcase
      imm_calc = XLEN'(signed'(imm32));
   end

   assign accept = bus.inValid & in_ready_q;
   assign xfer   = (state != EMPTY) & bus.outReady;

   // Occupancy FSM; in TWO inReady is low, so accept cannot occur there.
   always_comb begin
      state_next     = state;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_next    = ONE;
               load_main_new = 1'b1;
            end
         end
         ONE: begin
            if (accept && !xfer) begin
               state_next = TWO;
               load_skid  = 1'b1;
            end else if (accept && xfer) begin
               load_main_new = 1'b1;
            end else if (xfer) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            if (xfer) begin
               state_next     = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_next;
         in_ready_q <= (state_next != TWO);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_imm <= '0;
         main_tag <= '0;
         main_ill <= 1'b0;
         skid_imm <= '0;
         skid_tag <= '0;
         skid_ill <= 1'b0;
         err_cnt  <= '0;
      end else begin
         if (load_main_new) begin
            main_imm <= imm_calc;
            main_tag <= bus.inTag;
            main_ill <= ill_calc;
         end else if (load_main_skid) begin
            main_imm <= skid_imm;
            main_tag <= skid_tag;
            main_ill <= skid_ill;
         end
         if (load_skid) begin
            skid_imm <= imm_calc;
            skid_tag <= bus.inTag;
            skid_ill <= ill_calc;
         end
         if (accept && ill_calc && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
      end
   end

   assign bus.inReady  = in_ready_q;
   assign bus.outValid = (state != EMPTY);
   assign bus.imm      = main_imm;
   assign bus.outTag   = main_tag;
   assign bus.illegal  = main_ill;
   assign bus.errCount = err_cnt;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised successor to the decode-stage immediate generator.
- Accepts an instruction word, an immediate-format select and a sideband tag over a valid/ready handshake.
- Produces the XLEN-wide extended immediate one cycle later, with an illegal-format flag.
- Sits between fetch/decode and the execute stage; a 2-entry skid buffer absorbs downstream back-pressure without a combinational ready path.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 5, width of the opaque sideband tag carried alongside each instruction (e.g. rd index).
- ZIMM_EN, 1, when 1 extOp=5 selects the zero-extended CSR immediate; when 0, extOp=5 is illegal.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- inValid  input  1  upstream holds a valid instruction.
- inReady  output  1  block can accept this cycle.
- instr  input  32  instruction word.
- extOp  input  3  format select: 0 I, 1 U, 2 S, 3 B, 4 J, 5 Z (CSR zimm), 6/7 illegal.
- inTag  input  TAG_W  sideband tag.
- outValid  output  1  imm/outTag/illegal are valid.
- outReady  input  1  downstream accepts this cycle.
- imm  output  XLEN  extended immediate.
- outTag  output  TAG_W  tag of the entry presented.
- illegal  output  1  entry had an illegal extOp; imm is 0.
- errCount  output  8  saturating count of accepted illegal entries.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: outValid=0, imm=0, outTag=0, illegal=0, errCount=0. inReady=1 in the first cycle after reset deasserts.
- Reset mid-operation: both buffer entries are discarded and nothing is presented.
- Formats; "sext" means extend bit 31 to XLEN:
  - I: sext(instr[31:20]).
  - U: sext({instr[31:12], 12'b0}). For XLEN=64, bits 63:32 copy instr[31].
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Z: zero-extend instr[19:15].
- Immediate computation is combinational on the inputs; the result is captured at acceptance.
- Acceptance: inValid & inReady at a rising edge.
- Latency: an entry accepted at edge N is presented (outValid=1) from cycle N+1, if the output stage is free or frees in the same cycle.
- Transfer: outValid & outReady at an edge.
- Presented entry stability: outValid, imm, outTag and illegal stay constant until transfer. outValid never drops without a transfer, except on reset.
- Storage: main output register plus one skid register.
- inReady is a registered signal, 1 exactly when the skid register is empty. It never depends combinationally on outReady.
- State machine (occupancy):
  - EMPTY (0 entries): accept → ONE.
  - ONE:
    - accept with no transfer → TWO (new entry goes to skid).
    - accept with transfer → ONE (new entry goes to main).
    - transfer with no accept → EMPTY.
  - TWO:
    - inReady=0.
    - transfer → ONE; skid moves to main next cycle, preserving order.
    - no transfer → hold.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Throughput: 1 entry per cycle with outReady held high.
- Illegal handling: extOp 6/7 (or 5 when ZIMM_EN=0) flows normally with imm=0 and illegal=1.
- errCount increments by 1 on acceptance of an illegal entry and saturates at 255.
- Inputs are sampled only at acceptance; changes while inReady=0 have no effect.

Test Plan:
- Reset, then accept instr=0xFFF00093 extOp=0 tag=1 with outReady=1 → next cycle outValid=1, imm=0xFFFFFFFF, outTag=1, illegal=0.
- Back-to-back stream, outReady=1, one entry per cycle:
  - 0x12345037/1 → 0x12345000.
  - 0xFE112E23/2 → 0xFFFFFFFC.
  - 0xFE000CE3/3 → 0xFFFFFFF8.
  - 0x0080006F/4 → 0x00000008.
  - Required: consecutive outValid, order preserved, inReady never drops.
- Back-pressure: outReady=0 while 3 entries are offered → first held stable in the output, second in skid, inReady=0 the cycle after the second acceptance, third not taken. Raise outReady → all three emerge in order, one per cycle.
- Illegal: extOp=6, then extOp=7, then extOp=5 with instr[19:15]=0x1F → imm=0 and illegal=1 twice, then imm=0x1F with illegal=0; errCount=2. Feeding 300 illegal entries saturates errCount at 255.
- XLEN=64: 0x80000037 extOp=1 → imm=0xFFFFFFFF80000000. 0x7FF00093 extOp=0 → 0x00000000000007FF.
- Reset asserted with both entries full → next cycle outValid=0, inReady=1, errCount=0; next accepted entry appears normally with no stale output.
